// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: RV32M funct3 codes, decode constants and the
// sequencer state encoding.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_REG        = 7'h33;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rv32m_muldiv_seq_if.sv
// Request/response channels between the execute stage and the multi-cycle
// multiply/divide sequencer.
interface rv32m_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output req_valid, req_funct3, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_funct3, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restore-subtract for divide.
// {acc_hi, acc_lo} is product/multiplier or remainder/dividend-quotient.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc_hi,
    input  logic [W-1:0] acc_lo,
    input  logic [W-1:0] operand,
    input  logic         is_div,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next
);
    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[W-1]};
        ge      = (shifted >= {1'b0, operand});
        // When ge holds the true difference is below operand, so W bits suffice.
        diff    = shifted[W-1:0] - operand;
        if (is_div) begin
            hi_next = ge ? diff : shifted[W-1:0];
            lo_next = {acc_lo[W-2:0], ge};
        end else begin
            hi_next = sum[W:1];
            lo_next = {sum[0], acc_lo[W-1:1]};
        end
    end
endmodule

// File: rtl/rv32m_muldiv_seq.sv
// Multi-cycle RV32M sequencer: iterates on operand magnitudes for ITER cycles,
// then sign-corrects; divide-by-zero and signed overflow resolve immediately.
module rv32m_muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    output logic               busy,
    rv32m_muldiv_seq_if.slave  bus
);
    import rv32_pkg::*;

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [2:0]      op_reg;
    logic            neg_reg;
    logic            rem_neg_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] opnd_reg;
    logic [XLEN-1:0] resp_result_reg;
    logic            req_ready_reg;
    logic            resp_valid_reg;
    logic            busy_reg;

    logic [2:0]      f3;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic            special;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] fin_result;

    assign f3 = bus.req_funct3;

    // Magnitudes stay XLEN wide: |0x80000000| = 2^31 is exact as unsigned.
    always_comb begin
        a_signed = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
        b_signed = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
        a_neg    = a_signed & bus.req_a[XLEN-1];
        b_neg    = b_signed & bus.req_b[XLEN-1];
        a_mag    = a_neg ? -bus.req_a : bus.req_a;
        b_mag    = b_neg ? -bus.req_b : bus.req_b;
        special        = 1'b0;
        special_result = '0;
        if (f3[2] && (bus.req_b == '0)) begin
            special        = 1'b1;
            special_result = f3[1] ? bus.req_a : '1;
        end else if (((f3 == F3_DIV) || (f3 == F3_REM)) &&
                     (bus.req_a == MIN_NEG) && (bus.req_b == '1)) begin
            special        = 1'b1;
            special_result = (f3 == F3_DIV) ? MIN_NEG : '0;
        end
    end

    muldiv_step #(.W(XLEN)) u_step (
        .acc_hi  (hi_reg),
        .acc_lo  (lo_reg),
        .operand (opnd_reg),
        .is_div  (op_reg[2]),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_comb begin
        prod     = {hi_reg, lo_reg};
        prod_fix = neg_reg ? -prod : prod;
        case (op_reg)
            F3_MUL:                       fin_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_result = neg_reg ? -lo_reg : lo_reg;
            default:                      fin_result = rem_neg_reg ? -hi_reg : hi_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            op_reg          <= F3_MUL;
            neg_reg         <= 1'b0;
            rem_neg_reg     <= 1'b0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            opnd_reg        <= '0;
            resp_result_reg <= '0;
            req_ready_reg   <= 1'b1;
            resp_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else if (flush) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_reg        <= f3;
                        neg_reg       <= a_neg ^ b_neg;
                        rem_neg_reg   <= a_neg;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (special) begin
                            resp_result_reg <= special_result;
                            resp_valid_reg  <= 1'b1;
                            state_reg       <= DONE;
                        end else begin
                            // Multiply keeps the multiplier in lo; divide keeps the dividend there.
                            hi_reg    <= '0;
                            lo_reg    <= f3[2] ? a_mag : b_mag;
                            opnd_reg  <= f3[2] ? b_mag : a_mag;
                            count_reg <= '0;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(ITER - 1)) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    resp_result_reg <= fin_result;
                    resp_valid_reg  <= 1'b1;
                    state_reg       <= DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.resp_result = resp_result_reg;
    assign busy            = busy_reg;

endmodule
